// File: rtl/operand_requester_pkg.sv
// ============================================================================
// Module   : operand_requester_pkg
// Brief    : Shared types, constants and helpers for the operand requester
//            (request struct, VRF beat address, queue index, FSM states).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package operand_requester_pkg;

  localparam int unsigned VLENB        = 16;  // bytes per vector register
  localparam int unsigned DataWidthB   = 4;   // bytes per VRF read beat
  localparam int unsigned NrVRegs      = 32;  // architectural vector registers
  localparam int unsigned FifoDepth    = 2;   // entries per operand queue (>= 2)

  localparam int unsigned BeatsPerVReg = VLENB / DataWidthB;
  localparam int unsigned VrfAddrW     = $clog2(NrVRegs * BeatsPerVReg);
  localparam int unsigned DataW        = 8 * DataWidthB;
  localparam int unsigned VlenW        = 16;
  localparam int unsigned FifoCntW     = $clog2(FifoDepth + 1);

  typedef logic [VrfAddrW-1:0] vrf_addr_t;
  typedef logic [DataW-1:0]    vrf_data_t;
  typedef logic [VlenW-1:0]    vlen_t;

  typedef struct packed {
    logic [4:0] vs1;
    logic [4:0] vs2;
    logic [1:0] queue_req;
    vlen_t      vlB;
  } op_req_t;

  typedef enum logic {
    OpQueueVs1 = 1'b0,
    OpQueueVs2 = 1'b1
  } opq_idx_e;

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } state_e;

  // First beat address of a vector register.
  function automatic vrf_addr_t GetVRFAddr(input logic [4:0] vreg);
    return vrf_addr_t'(vreg) * vrf_addr_t'(BeatsPerVReg);
  endfunction

  // Number of read beats needed to cover vlB bytes (rounded up).
  function automatic vlen_t GetNumBeats(input vlen_t vlB);
    return vlen_t'((17'(vlB) + 17'(DataWidthB - 1)) / 17'(DataWidthB));
  endfunction

endpackage

`default_nettype wire

// File: rtl/operand_requester_if.sv
// ============================================================================
// Module   : operand_requester_if
// Brief    : Request, VRF read and operand queue signals of the requester.
//            Signal suffixes are from the requester's point of view.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface operand_requester_if;
  import operand_requester_pkg::*;

  logic            op_req_valid_i;
  logic            op_req_ready_o;
  op_req_t         op_req_i;
  logic            vrf_rd_req_o;
  vrf_addr_t       vrf_rd_addr_o;
  logic            vrf_rd_gnt_i;
  vrf_data_t       vrf_rd_data_i;
  logic [1:0]      opq_valid_o;
  logic [1:0]      opq_ready_i;
  vrf_data_t [1:0] opq_data_o;
  logic [1:0]      opq_last_o;

  // Requester side
  modport slave (
    input  op_req_valid_i, op_req_i, vrf_rd_gnt_i, vrf_rd_data_i, opq_ready_i,
    output op_req_ready_o, vrf_rd_req_o, vrf_rd_addr_o, opq_valid_o, opq_data_o,
           opq_last_o
  );

  // Launcher / VRF / functional-unit side
  modport master (
    output op_req_valid_i, op_req_i, vrf_rd_gnt_i, vrf_rd_data_i, opq_ready_i,
    input  op_req_ready_o, vrf_rd_req_o, vrf_rd_addr_o, opq_valid_o, opq_data_o,
           opq_last_o
  );

endinterface

`default_nettype wire

// File: rtl/operand_requester_op_fifo.sv
// ============================================================================
// Module   : op_fifo
// Brief    : First-word-fall-through FIFO with occupancy count. Push and pop
//            in the same cycle are allowed even when full.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module op_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic                       valid_o,
  output logic [WIDTH-1:0]           data_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= next_ptr(wr_ptr_q);
      if (pop_i)  rd_ptr_q <= next_ptr(rd_ptr_q);
      count_q <= count_q + CNT_W'(push_i) - CNT_W'(pop_i);
    end
  end

  // Storage array; contents are don't-care while the count says empty.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign valid_o = (count_q != '0);
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push_i && !pop_i && (count_q == CNT_W'(DEPTH))));

endmodule

`default_nettype wire

// File: rtl/operand_requester.sv
// ============================================================================
// Module   : operand_requester
// Brief    : Takes one operand request per instruction, reads vs1/vs2 from a
//            single-port VRF beat by beat with round-robin arbitration and
//            pushes the data into two per-source FWFT operand queues.
//            Optional: OPREQ_PERF_CNT_EN adds stall_cnt_o (grant-stall count).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module operand_requester
  import operand_requester_pkg::*;
(
  input  logic                      clk_i,
  input  logic                      rst_ni,
  operand_requester_if.slave        bus,
  output logic                      busy_o
`ifdef OPREQ_PERF_CNT_EN
  ,
  output logic [31:0]               stall_cnt_o
`endif
);

  state_e    state_q, state_d;
  logic [1:0] pend_q, pend_d;
  logic [1:0] inflight_q, inflight_d;
  logic [1:0] last_q, last_d;
  vlen_t     beats_q [2];
  vlen_t     beats_d [2];
  vrf_addr_t addr_q [2];
  vrf_addr_t addr_d [2];
  logic      rr_q, rr_d;
  logic      hold_q, hold_d;
  logic      hold_src_q, hold_src_d;

  logic [1:0]          elig;
  logic [FifoCntW:0]   occ [2];
  logic [FifoCntW-1:0] fifo_cnt [2];
  logic [DataW:0]      fifo_data [2];
  logic [1:0]          fifo_valid;
  logic [1:0]          fifo_last;
  vrf_data_t [1:0]     fifo_dout;
  logic [1:0]          opq_pop;
  logic                sel;
  logic                rd_req;
  logic                grant;
  logic                req_ready;

  assign opq_pop = bus.opq_ready_i & fifo_valid;

  // Credit check: queued + in-flight beats must leave room; a pop in the
  // same cycle frees its slot so a ready consumer sees back-to-back reads.
  always_comb begin
    for (int s = 0; s < 2; s++) begin
      occ[s]  = {1'b0, fifo_cnt[s]} + (FifoCntW+1)'(inflight_q[s])
              - (FifoCntW+1)'(opq_pop[s]);
      elig[s] = (state_q == READ) && pend_q[s]
              && (occ[s] < (FifoCntW+1)'(FifoDepth));
    end
  end

  // Source selection: an ungranted request keeps its source while eligible.
  always_comb begin
    sel = 1'b0;
    if (hold_q && elig[hold_src_q]) sel = hold_src_q;
    else if (elig == 2'b11)         sel = rr_q;
    else                            sel = elig[1];
  end

  assign rd_req = |elig;
  assign grant  = rd_req && bus.vrf_rd_gnt_i;

  // Next-state logic: request capture in IDLE, beat sequencing in READ.
  always_comb begin
    logic [4:0] vreg;
    vreg       = '0;
    state_d    = state_q;
    pend_d     = pend_q;
    beats_d    = beats_q;
    addr_d     = addr_q;
    rr_d       = rr_q;
    inflight_d = '0;
    last_d     = '0;
    hold_d     = rd_req && !bus.vrf_rd_gnt_i;
    hold_src_d = sel;
    req_ready  = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (bus.op_req_valid_i) begin
          for (int s = 0; s < 2; s++) begin
            vreg       = (s == int'(OpQueueVs1)) ? bus.op_req_i.vs1 : bus.op_req_i.vs2;
            pend_d[s]  = bus.op_req_i.queue_req[s] && (bus.op_req_i.vlB != '0);
            beats_d[s] = GetNumBeats(bus.op_req_i.vlB);
            addr_d[s]  = GetVRFAddr(vreg);
          end
          if (pend_d != '0) state_d = READ;
        end
      end
      READ: begin
        if (grant) begin
          addr_d[sel]     = addr_q[sel] + 1'b1;
          beats_d[sel]    = beats_q[sel] - 1'b1;
          inflight_d[sel] = 1'b1;
          last_d[sel]     = (beats_q[sel] == vlen_t'(1));
          if (beats_q[sel] == vlen_t'(1)) pend_d[sel] = 1'b0;
          rr_d = ~rr_q;
        end
        if (pend_d == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state registers; reset discards all sequencing state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      pend_q     <= '0;
      inflight_q <= '0;
      last_q     <= '0;
      beats_q    <= '{default: '0};
      addr_q     <= '{default: '0};
      rr_q       <= 1'b0;
      hold_q     <= 1'b0;
      hold_src_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      inflight_q <= inflight_d;
      last_q     <= last_d;
      beats_q    <= beats_d;
      addr_q     <= addr_d;
      rr_q       <= rr_d;
      hold_q     <= hold_d;
      hold_src_q <= hold_src_d;
    end
  end

  for (genvar s = 0; s < 2; s++) begin : g_opq
    op_fifo #(
      .DEPTH (FifoDepth),
      .WIDTH (DataW + 1)
    ) u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (inflight_q[s]),
      .data_i  ({last_q[s], bus.vrf_rd_data_i}),
      .pop_i   (opq_pop[s]),
      .valid_o (fifo_valid[s]),
      .data_o  (fifo_data[s]),
      .count_o (fifo_cnt[s])
    );
    assign fifo_last[s] = fifo_data[s][DataW];
    assign fifo_dout[s] = fifo_data[s][DataW-1:0];
  end

  assign bus.op_req_ready_o = req_ready;
  assign bus.vrf_rd_req_o   = rd_req;
  assign bus.vrf_rd_addr_o  = addr_q[sel];
  assign bus.opq_valid_o    = fifo_valid;
  assign bus.opq_data_o     = fifo_dout;
  assign bus.opq_last_o     = fifo_last;
  assign busy_o = (state_q != IDLE) || (inflight_q != '0) || (fifo_valid != '0);

`ifdef OPREQ_PERF_CNT_EN
  logic [31:0] stall_cnt_q;

  // Saturating count of READ cycles with work pending but no grant.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_q <= '0;
    end else if ((state_q == READ) && (pend_q != '0) && !grant && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

`default_nettype wire

// File: doc/operand_requester.md
Name: operand_requester

Overview:
- Sits directly downstream of the vector instruction launcher.
- Accepts one operand request per instruction: vs1/vs2 register indices, a per-source queue mask and a byte length.
- Sequences single-port VRF reads beat by beat, arbitrating between the two sources.
- Pushes the returned read data into two per-source operand queues that feed the functional units.

Parameters:
- VLENB, 16, bytes per vector register.
- DataWidthB, 4, bytes per VRF read beat; must divide VLENB.
- NrVRegs, 32, number of architectural vector registers.
- FifoDepth, 2, entries per operand queue; must be ≥2.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  async active-low reset
- op_req_valid_i  in  1  operand request valid
- op_req_ready_o  out  1  request accepted when valid&ready
- op_req_i  in  op_req_t  {vs1[4:0], vs2[4:0], queue_req[1:0], vlB}
- vrf_rd_req_o  out  1  VRF read request
- vrf_rd_addr_o  out  $clog2(NrVRegs*VLENB/DataWidthB)  beat address
- vrf_rd_gnt_i  in  1  read granted this cycle
- vrf_rd_data_i  in  8*DataWidthB  read data, valid exactly 1 cycle after grant
- opq_valid_o  out  2  operand queue head valid ([0]=vs1, [1]=vs2)
- opq_ready_i  in  2  consumer pops head
- opq_data_o  out  2x8*DataWidthB  head data
- opq_last_o  out  2  head is final beat of its source
- busy_o  out  1  request active or data in flight/queued

Behaviour:
- Reset values:
  - op_req_ready_o=1, vrf_rd_req_o=0, opq_valid_o=0, busy_o=0, round-robin pointer=0, FSM=IDLE.
- FSM states: IDLE, READ.
- IDLE:
  - op_req_ready_o=1.
  - On handshake, latch per source s∈{0,1} (source 0 uses vs1, source 1 uses vs2):
    - pend[s] = queue_req[s] && vlB≠0.
    - beats[s] = ceil(vlB/DataWidthB).
    - addr[s] = vreg*(VLENB/DataWidthB).
  - If no source pending: stay IDLE; zero reads issued.
  - Otherwise go to READ.
- READ:
  - op_req_ready_o=0.
  - Source s is eligible iff pend[s] && (fifo_count[s] + inflight[s] < FifoDepth).
  - vrf_rd_req_o = any eligible. Address is that of the selected source.
  - Selection: single eligible source wins. When both are eligible, the source equal to the rr pointer wins.
  - The pointer flips on every grant.
  - Request and address must be held stable until vrf_rd_gnt_i; re-selection is allowed only when the previously selected source loses eligibility.
  - On grant:
    - addr[s]++ and beats[s]--; inflight[s]=1 for one cycle.
    - When beats[s] reaches 0, pend[s]=0.
  - When both pend are 0, return to IDLE on the next cycle. Ready asserts in IDLE.
- Data return:
  - One cycle after grant, vrf_rd_data_i is pushed into fifo[s].
  - last is set iff the granted beat was the final beat of s.
  - The credit check guarantees a push never hits a full FIFO. A push to a full FIFO is a design error (assertion).
- Operand queues:
  - First-word-fall-through: opq_valid_o[s] = !empty.
  - A pop on opq_ready_i&&opq_valid_o occurs in the same cycle.
  - Simultaneous push and pop on a full FIFO is legal; the count is unchanged.
- Ordering: beats of a source reach its queue in ascending address order.
- Addresses: wrap modulo 2^addr width. A request that runs past v31 wraps to v0 and is not flagged.
- busy_o = (FSM≠IDLE) || any inflight || any fifo non-empty.
- Async reset mid-operation: counters, inflight and FIFOs are cleared immediately. Queued data is discarded.

Optional Feature:
- Macro: OPREQ_PERF_CNT_EN.
- Defined:
  - Adds output stall_cnt_o[31:0].
  - Increments each READ cycle with pend≠0 and no grant. Saturates at 2^32-1.
  - Reset value 0.
- Undefined: the port and counter do not exist; behaviour is otherwise identical.

Decomposition:
- Shared core package:
  - op_req_t.
  - vrf_addr_t.
  - DataWidthB/VLENB constants.
  - GetVRFAddr(vreg).
  - Operand queue index enum (OpQueueVs1=0, OpQueueVs2=1).
- Sub-module op_fifo:
  - Parameterised depth/width FWFT FIFO with count output.
  - Instantiated twice.

Test Plan:
- Basic read: vs1=3, queue_req=01, vlB=16, gnt always 1 → reads at addr 12,13,14,15 on consecutive cycles (consumer always ready). opq_last_o[0] asserts on the 4th beat only; ready returns after the last grant.
- Arbitration: vs1=1, vs2=2, queue_req=11, vlB=8, gnt=1 → address order 4,8,5,9 (rr starts at vs1); each queue receives 2 beats.
- Partial beat and no-op: vlB=5 → 2 beats. vlB=0 or queue_req=00 → accepted, zero reads, stays IDLE, ready stays 1.
- Backpressure: opq_ready_i[0]=0, vlB=16, FifoDepth=2 → exactly 2 reads issued, then vrf_rd_req_o=0. Releasing ready resumes reads with no data loss.
- Grant stall: hold vrf_rd_gnt_i=0 for 3 cycles → vrf_rd_req_o and address stay stable. With OPREQ_PERF_CNT_EN, stall_cnt_o increases by 3.
- Reset mid-request: assert rst_ni low after 2 of 4 beats → all outputs return to reset values immediately. A new request afterwards completes normally.
